// File: rtl/pow2_check_arbiter_pkg.sv
// pow2_check_arbiter_pkg: FSM encodings and scan constants shared by the pow2 arbiter files
package pow2_check_arbiter_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ONES_SAT = 2'd2;
endpackage

// File: rtl/pow2_check_arbiter_bit_scan.sv
// pow2_check_arbiter_bit_scan: serial scan of one operand bit per cycle, WIDTH cycles per operand
module pow2_check_arbiter_bit_scan
    import pow2_check_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LGW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_num,
    output logic             done,
    output logic             is_pow2,
    output logic [LGW-1:0]   log2
);
    logic [WIDTH-1:0] r_shift;
    logic [LGW-1:0]   r_bit_idx;
    logic [LGW-1:0]   r_pos;
    logic [1:0]       r_ones_cnt;
    logic             r_active;
    logic [1:0]       w_cnt_nxt;
    logic [LGW-1:0]   w_pos_nxt;
    // results include the bit being scanned now, so they are final in the done cycle
    always_comb begin
        w_cnt_nxt = (r_ones_cnt == ONES_SAT || !r_shift[0]) ? r_ones_cnt : r_ones_cnt + 2'd1;
        w_pos_nxt = (r_ones_cnt == 2'd0 && r_shift[0]) ? r_bit_idx : r_pos;
    end
    assign done    = r_active && r_bit_idx == LGW'(WIDTH - 1);
    assign is_pow2 = w_cnt_nxt == 2'd1;
    assign log2    = is_pow2 ? w_pos_nxt : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_ones_cnt <= '0;
            r_pos      <= '0;
        end else if (load) begin
            r_active   <= 1'b1;
            r_shift    <= load_num;
            r_bit_idx  <= '0;
            r_ones_cnt <= '0;
            r_pos      <= '0;
        end else if (r_active) begin
            r_active   <= !done;
            r_shift    <= r_shift >> 1;
            r_bit_idx  <= r_bit_idx + LGW'(1);
            r_ones_cnt <= w_cnt_nxt;
            r_pos      <= w_pos_nxt;
        end
    end
endmodule

// File: rtl/pow2_check_arbiter.sv
// pow2_check_arbiter: round-robin shared power-of-two checker with a valid/ready result port
module pow2_check_arbiter
    import pow2_check_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 2,
    localparam int IDW   = $clog2(NREQ),
    localparam int LGW   = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_num,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_is_pow2,
    output logic [LGW-1:0]        rsp_log2,
    input  logic                  rsp_ready,
    output logic                  busy
);
    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_next_ptr;
    logic           w_found;
    logic           w_accept;
    logic           w_done;
    logic           w_is_pow2;
    logic [LGW-1:0] w_log2;
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_grant = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
        w_next_ptr = (int'(w_grant) == NREQ - 1) ? '0 : w_grant + IDW'(1);
        w_accept   = r_state == ST_IDLE && w_found;
        req_ready  = w_accept ? NREQ'(1) << w_grant : '0;
    end
    pow2_check_arbiter_bit_scan #(.WIDTH(WIDTH), .LGW(LGW)) u_scan (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .load_num (req_num[w_grant*WIDTH +: WIDTH]),
        .done     (w_done),
        .is_pow2  (w_is_pow2),
        .log2     (w_log2)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_is_pow2 <= 1'b0;
            rsp_log2    <= '0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state  <= ST_SCAN;
                    r_rr_ptr <= w_next_ptr;
                    r_id     <= w_grant;
                    busy     <= 1'b1;
                end
                ST_SCAN: if (w_done) begin
                    r_state     <= ST_DONE;
                    rsp_valid   <= 1'b1;
                    rsp_id      <= r_id;
                    rsp_is_pow2 <= w_is_pow2;
                    rsp_log2    <= w_log2;
                end
                ST_DONE: if (rsp_ready) begin
                    r_state   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pow2_check_arbiter.sv
// tb_pow2_check_arbiter: directed and random checks of the shared pow2 arbiter against a behavioural model
module tb_pow2_check_arbiter;
    localparam int W = 8;
    localparam int N = 2;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_num = '0;
    logic [N-1:0] req_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic         rsp_is_pow2;
    logic [2:0]   rsp_log2;
    logic         rsp_ready = 1'b1;
    logic         busy;
    int checks = 0;
    int errors = 0;
    int m_phase = 0, m_cnt = 0, m_rr = 0, m_id = 0, m_lg = 0, mg = 0;
    int accepts = 0, rsps = 0;
    bit m_p2 = 0, m_init = 0, m_zero = 0;
    logic [N-1:0] m_er;
    logic [W-1:0] m_x;

    pow2_check_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_is_pow2(rsp_is_pow2), .rsp_log2(rsp_log2),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_p2(input logic [W-1:0] x);
        return x != 0 && (x & (x - 1'b1)) == 0;
    endfunction

    function automatic int lg_of(input logic [W-1:0] x);
        if (!is_p2(x)) return 0;
        for (int b = 0; b < W; b++) if (x[b]) return b;
        return 0;
    endfunction

    function automatic int grant_of(input int rr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // model phases: 0 waiting for a request, 1 scanning, 2 result offered
    always @(negedge clk) begin
        mg = grant_of(m_rr, req_valid);
        if (m_init) begin
            m_er = (m_phase == 0 && mg >= 0) ? N'(1 << mg) : '0;
            chk("m_req_ready", 32'(req_ready), 32'(m_er));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            if (m_phase == 2 || m_zero) begin
                chk("m_rsp_id", 32'(rsp_id), m_zero ? 0 : m_id);
                chk("m_rsp_is_pow2", 32'(rsp_is_pow2), m_zero ? 0 : 32'(m_p2));
                chk("m_rsp_log2", 32'(rsp_log2), m_zero ? 0 : m_lg);
            end
        end
        if (rst) begin
            m_init = 1; m_phase = 0; m_rr = 0; m_zero = 1;
        end else begin
            m_zero = 0;
            if (m_phase == 0 && mg >= 0) begin
                m_x = req_num[mg*W +: W];
                m_id = mg; m_p2 = is_p2(m_x); m_lg = lg_of(m_x);
                m_rr = (mg + 1) % N; m_phase = 1; m_cnt = 0; accepts++;
            end else if (m_phase == 1) begin
                m_cnt++;
                if (m_cnt == W) m_phase = 2;
            end else if (m_phase == 2 && rsp_ready) begin
                m_phase = 0; rsps++;
            end
        end
    end

    task automatic wait_ready(input logic [N-1:0] mask, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while ((req_ready & mask) == 0 && n < 40);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 40);
    endtask

    task automatic rst_pulse();
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_one(input int idx, input logic [W-1:0] num, input logic ep, input int el, input string nm);
        int n;
        req_num[idx*W +: W] = num;
        req_valid[idx] = 1'b1;
        wait_ready(N'(1 << idx), n);
        chk({nm, "_grant"}, 32'(req_ready), 32'(1 << idx));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_rsp(n);
        chk({nm, "_lat"}, n, 8);
        chk({nm, "_id"}, 32'(rsp_id), idx);
        chk({nm, "_p2"}, 32'(rsp_is_pow2), 32'(ep));
        chk({nm, "_log2"}, 32'(rsp_log2), el);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        int r;
        r = $urandom_range(0, 3);
        return r == 0 ? '0 : r == 1 ? W'(1 << $urandom_range(0, W - 1)) : r == 2 ? '1 : W'($urandom);
    endfunction

    initial begin
        int n, seen, a0, r0, cyc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        run_one(0, 8'd0, 1'b0, 0, "t1_zero");
        run_one(0, 8'd1, 1'b1, 0, "t2_1");
        run_one(0, 8'd2, 1'b1, 1, "t2_2");
        run_one(0, 8'd128, 1'b1, 7, "t2_128");
        run_one(0, 8'd255, 1'b0, 0, "t2_255");
        run_one(0, 8'd96, 1'b0, 0, "t2_96");
        rst_pulse();
        req_num = {8'd3, 8'd16};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(2'b11, n);
            chk("t3_onehot", $countones(req_ready), 1);
            chk("t3_grant", 32'(req_ready), (k % 2) ? 2 : 1);
            @(posedge clk); #1;
            wait_rsp(n);
            chk("t3_lat", n, 8);
            chk("t3_id", 32'(rsp_id), k % 2);
            chk("t3_p2", 32'(rsp_is_pow2), (k % 2) ? 0 : 1);
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        req_num = {8'd5, 8'd64};
        req_valid = 2'b01;
        wait_ready(2'b01, n);
        @(posedge clk); #1;
        req_valid = 2'b10;
        wait_rsp(n);
        chk("t4_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_p2", 32'(rsp_is_pow2), 1);
            chk("t4_hold_log2", 32'(rsp_log2), 6);
            chk("t4_hold_id", 32'(rsp_id), 0);
            chk("t4_no_accept", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        wait_ready(2'b11, n);
        chk("t4_next_grant", 32'(req_ready), 2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(n);
        chk("t4_next_id", 32'(rsp_id), 1);
        chk("t4_next_p2", 32'(rsp_is_pow2), 0);
        @(posedge clk); #1;
        req_num[7:0] = 8'd4;
        req_valid = 2'b01;
        wait_ready(2'b01, n);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_req_ready", 32'(req_ready), 0);
        chk("t5_rsp_id", 32'(rsp_id), 0);
        chk("t5_rsp_p2", 32'(rsp_is_pow2), 0);
        chk("t5_rsp_log2", 32'(rsp_log2), 0);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; seen |= int'(rsp_valid); end
        chk("t5_no_rsp", seen, 0);
        req_num = {8'd32, 8'd8};
        req_valid = 2'b11;
        @(negedge clk);
        chk("t5_rr0", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(n);
        chk("t5_rr0_id", 32'(rsp_id), 0);
        chk("t5_rr0_log2", 32'(rsp_log2), 3);
        @(posedge clk); #1;
        run_one(1, 8'd32, 1'b1, 5, "t5_req1");
        a0 = accepts; r0 = rsps; cyc = 0;
        while ((accepts - a0 < 1000 || m_phase != 0) && cyc < 40000) begin
            req_valid = (accepts - a0 < 1000) ? N'($urandom_range(0, 3)) : '0;
            for (int i = 0; i < N; i++) req_num[i*W +: W] = pick();
            rsp_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        chk("t6_accepts", accepts - a0, 1000);
        chk("t6_responses", rsps - r0, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
